// File: rtl/storage_arbiter.sv
// N-channel arbitrated front end for the matrix storage port: round-robin or fixed
// priority grant, bounded burst lock, and read-data steering back to the requester.
module storage_arbiter #(
  parameter int N_CH     = 4,
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 32,
  parameter int RD_LAT   = 1,
  parameter int RR_MODE  = 1,
  parameter int MAX_LOCK = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          i_req,
  input  logic [N_CH-1:0]          i_we,
  input  logic [N_CH-1:0]          i_lock,
  input  logic [N_CH*ADDR_W-1:0]   i_addr,
  input  logic [N_CH*DATA_W-1:0]   i_wdata,
  output logic [N_CH-1:0]          o_gnt,
  output logic [N_CH-1:0]          o_rvalid,
  output logic [DATA_W-1:0]        o_rdata,
  output logic                     o_mem_we,
  output logic [ADDR_W-1:0]        o_mem_addr,
  output logic [DATA_W-1:0]        o_mem_wdata,
  input  logic [DATA_W-1:0]        i_mem_rdata,
  output logic [2:0]               o_owner,
  output logic                     o_busy
);
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CNT_W = $clog2(MAX_LOCK + 1);

  typedef enum logic {UNLOCKED, LOCKED} lock_e;

  logic [N_CH-1:0][ADDR_W-1:0] addr_a;
  logic [N_CH-1:0][DATA_W-1:0] wdata_a;
  assign addr_a  = i_addr;
  assign wdata_a = i_wdata;

  lock_e             state_q, state_d;
  logic [CH_W-1:0]   ptr_q, ptr_d, lown_q, lown_d, excl_ch_q, excl_ch_d, gnt_idx;
  logic              excl_q, excl_d, gnt_any, rd_push, inflight, busy_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [N_CH-1:0]   req_m, excl_mask;
  int                scan;

  logic [RD_LAT:1]             vld_pipe;
  logic [RD_LAT:1][CH_W-1:0]   ch_pipe;

  // Grant selection; a force-released owner is masked for one cycle only if someone else waits.
  always_comb begin
    excl_mask = '0;
    if (excl_q) excl_mask[excl_ch_q] = 1'b1;
    req_m = i_req;
    if (excl_q && ((i_req & ~excl_mask) != '0)) req_m = i_req & ~excl_mask;
    gnt_any = 1'b0;
    gnt_idx = '0;
    scan    = 0;
    if (!rst) begin
      if (state_q == LOCKED) begin
        gnt_any = i_req[lown_q];
        gnt_idx = lown_q;
      end else if (RR_MODE != 0) begin
        // descending scan so the last hit is the first requester at/after the pointer
        for (int i = N_CH-1; i >= 0; i--) begin
          scan = int'(ptr_q) + i;
          if (scan >= N_CH) scan = scan - N_CH;
          if (req_m[CH_W'(scan)]) begin
            gnt_any = 1'b1;
            gnt_idx = CH_W'(scan);
          end
        end
      end else begin
        for (int i = N_CH-1; i >= 0; i--) begin
          if (req_m[i]) begin
            gnt_any = 1'b1;
            gnt_idx = CH_W'(i);
          end
        end
      end
    end
    o_gnt = '0;
    if (gnt_any) o_gnt[gnt_idx] = 1'b1;
  end

  assign o_mem_we    = gnt_any & i_we[gnt_idx];
  assign o_mem_addr  = gnt_any ? addr_a[gnt_idx]  : '0;
  assign o_mem_wdata = gnt_any ? wdata_a[gnt_idx] : '0;
  assign rd_push     = gnt_any & ~i_we[gnt_idx];

  assign cnt_inc = (state_q == LOCKED) ? cnt_q + CNT_W'(1) : CNT_W'(1);

  always_comb begin
    state_d   = state_q;
    lown_d    = lown_q;
    cnt_d     = cnt_q;
    excl_d    = 1'b0;
    excl_ch_d = excl_ch_q;
    ptr_d     = ptr_q;
    if (gnt_any) begin
      ptr_d = (gnt_idx == CH_W'(N_CH-1)) ? '0 : gnt_idx + CH_W'(1);
      if (!i_lock[gnt_idx]) begin
        state_d = UNLOCKED;
        cnt_d   = '0;
      end else if (cnt_inc >= CNT_W'(MAX_LOCK)) begin
        state_d   = UNLOCKED;
        cnt_d     = '0;
        excl_d    = 1'b1;
        excl_ch_d = gnt_idx;
      end else begin
        state_d = LOCKED;
        lown_d  = gnt_idx;
        cnt_d   = cnt_inc;
      end
    end else if (state_q == LOCKED) begin
      state_d = UNLOCKED;
      cnt_d   = '0;
    end
  end

  // Busy tracks next-cycle contents: lock held or any read still owed a return strobe.
  always_comb begin
    inflight = rd_push;
    for (int s = 1; s < RD_LAT; s++) inflight = inflight | vld_pipe[s];
    busy_d = (state_d == LOCKED) | inflight;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= UNLOCKED;
      ptr_q     <= '0;
      lown_q    <= '0;
      cnt_q     <= '0;
      excl_q    <= 1'b0;
      excl_ch_q <= '0;
      o_owner   <= '0;
      o_busy    <= 1'b0;
      vld_pipe  <= '0;
      ch_pipe   <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      lown_q    <= lown_d;
      cnt_q     <= cnt_d;
      excl_q    <= excl_d;
      excl_ch_q <= excl_ch_d;
      o_busy    <= busy_d;
      if (gnt_any) o_owner <= 3'(gnt_idx);
      vld_pipe[1] <= rd_push;
      ch_pipe[1]  <= gnt_idx;
      for (int s = 2; s <= RD_LAT; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        ch_pipe[s]  <= ch_pipe[s-1];
      end
    end
  end

  always_comb begin
    o_rvalid = '0;
    if (!rst && vld_pipe[RD_LAT]) o_rvalid[ch_pipe[RD_LAT]] = 1'b1;
  end
  assign o_rdata = i_mem_rdata;

endmodule

// File: tb/tb_storage_arbiter.sv
// Self-checking bench for storage_arbiter: RR + fixed instances, write-first storage
// model with 2-cycle read latency, read returns checked through a scoreboard queue.
module tb_storage_arbiter;
  localparam int N = 4, AW = 9, DW = 32, LAT = 2, ML = 4;

  typedef struct {
    int          ch;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic clk, rst;
  logic [N-1:0]    req, we, lock;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]    gnt, rvalid, f_gnt, f_rvalid;
  logic [DW-1:0]   rdata, mem_wdata, mem_rdata, f_rdata, f_mem_wdata;
  logic [AW-1:0]   mem_addr, f_mem_addr;
  logic            mem_we, busy, f_mem_we, f_busy;
  logic [2:0]      owner, f_owner;
  logic [DW-1:0]   zero_rdata;

  logic [31:0] mem [0:511];
  logic [8:0]  a1, a2;
  logic        pl_en;
  logic [8:0]  pl_addr;
  logic [31:0] pl_data;

  exp_t sbq[$];
  int   checks = 0, errors = 0, cyc_n = 0;

  storage_arbiter #(.N_CH(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT), .RR_MODE(1), .MAX_LOCK(ML)) u_dut (
    .clk(clk), .rst(rst), .i_req(req), .i_we(we), .i_lock(lock), .i_addr(addr), .i_wdata(wdata),
    .o_gnt(gnt), .o_rvalid(rvalid), .o_rdata(rdata), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata), .o_owner(owner), .o_busy(busy));

  storage_arbiter #(.N_CH(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT), .RR_MODE(0), .MAX_LOCK(ML)) u_fix (
    .clk(clk), .rst(rst), .i_req(req), .i_we(we), .i_lock(lock), .i_addr(addr), .i_wdata(wdata),
    .o_gnt(f_gnt), .o_rvalid(f_rvalid), .o_rdata(f_rdata), .o_mem_we(f_mem_we), .o_mem_addr(f_mem_addr),
    .o_mem_wdata(f_mem_wdata), .i_mem_rdata(zero_rdata), .o_owner(f_owner), .o_busy(f_busy));

  assign zero_rdata = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // write-first storage, data appears LAT cycles after the address
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    if (mem_we) mem[mem_addr] <= mem_wdata;
    a1 <= mem_addr;
    a2 <= a1;
  end
  assign mem_rdata = mem[a2];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  task automatic idle();
    req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
  endtask

  task automatic set_ch(input int k, input logic w, input logic [8:0] a, input logic [31:0] d);
    we[k] = w;
    addr[k*AW +: AW] = a;
    wdata[k*DW +: DW] = d;
  endtask

  task automatic adv();
    @(posedge clk);
    cyc_n++;
    #1;
  endtask

  // settle to the negative edge and drain any read return into the scoreboard
  task automatic settle();
    exp_t e;
    logic [3:0] oh;
    @(negedge clk);
    if (rvalid !== '0) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL rvalid_unexpected: got rvalid=%b rdata=%h at cycle %0d, expected none", rvalid, rdata, cyc_n);
      end else begin
        e = sbq.pop_front();
        oh = 4'b0001 << e.ch;
        if (rvalid !== oh || rdata !== e.data || cyc_n != e.due) begin
          errors++;
          $display("FAIL read_return: got rvalid=%b rdata=%h cycle=%0d, expected rvalid=%b rdata=%h cycle=%0d",
                   rvalid, rdata, cyc_n, oh, e.data, e.due);
        end
      end
    end else if (sbq.size() != 0 && sbq[0].due <= cyc_n) begin
      checks++;
      errors++;
      $display("FAIL read_missing: got no rvalid at cycle %0d, expected ch%0d data %h", cyc_n, sbq[0].ch, sbq[0].data);
      void'(sbq.pop_front());
    end
  endtask

  task automatic preload(input logic [8:0] a, input logic [31:0] d);
    idle();
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    settle(); adv();
    pl_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle();
    settle(); adv();
    req = 4'b1111; we = 4'b0000;
    for (int k = 0; k < N; k++) set_ch(k, 1'b0, 9'h1FF, 32'hFFFF_FFFF);
    settle();
    checks++;
    if (gnt !== '0 || f_gnt !== '0 || mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
      errors++;
      $display("FAIL reset_port: got gnt=%b fgnt=%b we=%b addr=%h wdata=%h, expected all 0",
               gnt, f_gnt, mem_we, mem_addr, mem_wdata);
    end
    adv();
    idle(); rst = 1'b0;
    settle();
    checks++;
    if (owner !== 3'd0 || busy !== 1'b0 || rvalid !== '0) begin
      errors++;
      $display("FAIL reset_state: got owner=%0d busy=%b rvalid=%b, expected 0 0 0000", owner, busy, rvalid);
    end
    adv();
  endtask

  task automatic test_rr();
    logic [3:0] exp_g;
    idle(); req = 4'b1111; we = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      exp_g = 4'b0001 << (i % 4);
      settle();
      checks++;
      if (gnt !== exp_g) begin
        errors++;
        $display("FAIL rr_gnt[%0d]: got %b, expected %b", i, gnt, exp_g);
      end
      checks++;
      if (f_gnt !== 4'b0001) begin
        errors++;
        $display("FAIL fixed_all[%0d]: got %b, expected 0001", i, f_gnt);
      end
      if (i > 0) begin
        checks++;
        if (owner !== 3'((i - 1) % 4)) begin
          errors++;
          $display("FAIL rr_owner[%0d]: got %0d, expected %0d", i, owner, (i - 1) % 4);
        end
      end
      adv();
    end
  endtask

  task automatic test_fixed();
    logic [3:0] exp_g;
    idle(); req = 4'b1010; we = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      exp_g = (c % 2 == 0) ? 4'b0010 : 4'b1000;
      settle();
      checks++;
      if (f_gnt !== 4'b0010) begin
        errors++;
        $display("FAIL fixed_prio[%0d]: got %b, expected 0010", c, f_gnt);
      end
      checks++;
      if (gnt !== exp_g) begin
        errors++;
        $display("FAIL rr_1010[%0d]: got %b, expected %b", c, gnt, exp_g);
      end
      adv();
    end
  endtask

  task automatic test_read_steer();
    preload(9'd37, 32'hDEADBEEF);
    idle(); req = 4'b0100; set_ch(2, 1'b0, 9'd37, 32'h0);
    settle();
    checks++;
    if (gnt !== 4'b0100 || mem_addr !== 9'd37 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL steer_issue: got gnt=%b addr=%0d we=%b, expected 0100 37 0", gnt, mem_addr, mem_we);
    end
    sbq.push_back('{ch: 2, data: 32'hDEADBEEF, due: cyc_n + LAT});
    adv();
    idle();
    settle();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL steer_busy: got %b, expected 1", busy);
    end
    adv();
    for (int c = 0; c < 2; c++) begin settle(); adv(); end
  endtask

  task automatic test_lock();
    logic [3:0] exp_seq [7];
    exp_seq = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b1000, 4'b0001, 4'b0010};
    idle(); req = 4'b0001; we = 4'b0001;
    settle();
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL lock_prep: got %b, expected 0001", gnt);
    end
    adv();
    req = 4'b1011; we = 4'b1111; lock = 4'b0010;
    for (int c = 0; c < 7; c++) begin
      settle();
      checks++;
      if (gnt !== exp_seq[c]) begin
        errors++;
        $display("FAIL lock_seq[%0d]: got %b, expected %b", c, gnt, exp_seq[c]);
      end
      adv();
    end
    idle();
    settle();
    checks++;
    if (gnt !== '0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL lock_hold: got gnt=%b busy=%b, expected 0000 1", gnt, busy);
    end
    adv();
    settle();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL lock_release: got busy=%b, expected 0", busy);
    end
    adv();
  endtask

  task automatic test_wr_rd();
    idle(); req = 4'b0001; set_ch(0, 1'b1, 9'd100, 32'h0000_0005);
    settle();
    checks++;
    if (gnt !== 4'b0001 || mem_we !== 1'b1 || mem_addr !== 9'd100 || mem_wdata !== 32'h5) begin
      errors++;
      $display("FAIL wr_port: got gnt=%b we=%b addr=%0d wdata=%h, expected 0001 1 100 5",
               gnt, mem_we, mem_addr, mem_wdata);
    end
    adv();
    idle(); req = 4'b0100; set_ch(2, 1'b0, 9'd100, 32'h0);
    settle();
    checks++;
    if (gnt !== 4'b0100 || mem_we !== 1'b0 || mem_addr !== 9'd100) begin
      errors++;
      $display("FAIL rd_port: got gnt=%b we=%b addr=%0d, expected 0100 0 100", gnt, mem_we, mem_addr);
    end
    sbq.push_back('{ch: 2, data: 32'h0000_0005, due: cyc_n + LAT});
    adv();
    idle();
    for (int c = 0; c < 3; c++) begin settle(); adv(); end
  endtask

  task automatic test_back_to_back();
    preload(9'd10, 32'hA5A5_0001);
    preload(9'd11, 32'h5A5A_0002);
    idle(); req = 4'b0010; set_ch(1, 1'b0, 9'd10, 32'h0);
    settle();
    checks++;
    if (gnt !== 4'b0010) begin
      errors++;
      $display("FAIL b2b_gnt1: got %b, expected 0010", gnt);
    end
    sbq.push_back('{ch: 1, data: 32'hA5A5_0001, due: cyc_n + LAT});
    adv();
    idle(); req = 4'b1000; set_ch(3, 1'b0, 9'd11, 32'h0);
    settle();
    checks++;
    if (gnt !== 4'b1000) begin
      errors++;
      $display("FAIL b2b_gnt3: got %b, expected 1000", gnt);
    end
    sbq.push_back('{ch: 3, data: 32'h5A5A_0002, due: cyc_n + LAT});
    adv();
    idle();
    for (int c = 0; c < 3; c++) begin settle(); adv(); end
  endtask

  task automatic test_reset_mid();
    idle(); req = 4'b1000; lock = 4'b1000; set_ch(3, 1'b0, 9'd11, 32'h0);
    settle();
    checks++;
    if (gnt !== 4'b1000) begin
      errors++;
      $display("FAIL mid_gnt: got %b, expected 1000", gnt);
    end
    adv();
    rst = 1'b1;
    settle();
    checks++;
    if (gnt !== '0 || rvalid !== '0) begin
      errors++;
      $display("FAIL mid_in_reset: got gnt=%b rvalid=%b, expected 0000 0000", gnt, rvalid);
    end
    adv();
    rst = 1'b0; idle();
    settle();
    checks++;
    if (rvalid !== '0 || busy !== 1'b0 || owner !== 3'd0) begin
      errors++;
      $display("FAIL mid_after: got rvalid=%b busy=%b owner=%0d, expected 0000 0 0", rvalid, busy, owner);
    end
    adv();
    req = 4'b0111; we = 4'b1111;
    settle();
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL mid_first_gnt: got %b, expected 0001", gnt);
    end
    adv();
    idle();
    for (int c = 0; c < 3; c++) begin settle(); adv(); end
  endtask

  initial begin
    rst = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    idle();
    test_reset();
    test_rr();
    test_fixed();
    test_read_steer();
    test_lock();
    test_wr_rd();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending reads, expected 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
